// File: rtl/vec_stream_if.sv
// vec_stream_if: host write port (wr_*) and consumer stream port (m_*, frame_sent, banks_full) of vec_stream_tx
interface vec_stream_if #(parameter int WIDTH = 8);
  logic signed [WIDTH-1:0] wr_data;
  logic wr_valid;
  logic wr_ready;
  logic signed [WIDTH-1:0] m_data_out;
  logic m_valid;
  logic m_ready;
  logic frame_sent;
  logic [1:0] banks_full;
  modport master (
    input  wr_data, wr_valid, m_ready,
    output wr_ready, m_data_out, m_valid, frame_sent, banks_full
  );
  modport slave (
    output wr_data, wr_valid, m_ready,
    input  wr_ready, m_data_out, m_valid, frame_sent, banks_full
  );
endinterface

// File: rtl/vec_stream_tx.sv
// vec_stream_tx: ping-pong LEN-sample frame buffer streamed out over valid/ready; ports clk, reset, bus (vec_stream_if.master)
module vec_stream_tx #(
  parameter int WIDTH  = 8,
  parameter int LEN    = 5,
  parameter int LOGLEN = 3
) (
  input logic clk,
  input logic reset,
  vec_stream_if.master bus
);
  localparam logic [LOGLEN-1:0] LAST = LOGLEN'(LEN - 1);
  localparam logic [LOGLEN-1:0] DONE = LOGLEN'(LEN);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic signed [WIDTH-1:0] mem [2][LEN];
  logic [1:0] full;
  logic [1:0] set_full;
  logic [1:0] clr_full;
  logic wbank;
  logic rbank;
  logic [LOGLEN-1:0] widx;
  logic [LOGLEN-1:0] ridx;
  logic wr_acc;
  logic rd_last;
  assign bus.wr_ready = !reset && !full[wbank];
  assign wr_acc = bus.wr_valid && bus.wr_ready;
  assign rd_last = state == SEND && bus.m_valid && bus.m_ready && ridx == DONE;
  assign set_full = {2{wr_acc && widx == LAST}} & (wbank ? 2'b10 : 2'b01);
  assign clr_full = {2{rd_last}} & (rbank ? 2'b10 : 2'b01);
  assign bus.banks_full = full;
  always_ff @(posedge clk)
    if (reset) begin
      state          <= IDLE;
      full           <= '0;
      wbank          <= 1'b0;
      rbank          <= 1'b0;
      widx           <= '0;
      ridx           <= '0;
      bus.m_valid    <= 1'b0;
      bus.m_data_out <= '0;
      bus.frame_sent <= 1'b0;
    end else begin
      bus.frame_sent <= rd_last;
      full <= (full | set_full) & ~clr_full;
      if (wr_acc) begin
        mem[wbank][widx] <= bus.wr_data;
        widx  <= widx == LAST ? '0 : widx + 1'b1;
        wbank <= widx == LAST ? ~wbank : wbank;
      end
      if (state == IDLE) begin
        if (full[rbank]) begin
          bus.m_data_out <= mem[rbank][0];
          bus.m_valid    <= 1'b1;
          ridx           <= LOGLEN'(1);
          state          <= SEND;
        end
      end else if (bus.m_valid && bus.m_ready) begin
        if (ridx == DONE) begin
          rbank <= ~rbank;
          if (full[~rbank]) begin
            bus.m_data_out <= mem[~rbank][0];
            ridx           <= LOGLEN'(1);
          end else begin
            bus.m_valid <= 1'b0;
            ridx        <= '0;
            state       <= IDLE;
          end
        end else begin
          bus.m_data_out <= mem[rbank][ridx];
          ridx           <= ridx + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_vec_stream_tx.sv
// tb_vec_stream_tx: scoreboard bench for vec_stream_tx with directed frames
module tb_vec_stream_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fs_cnt = 0;
  int last_fs = 0;
  int prev_fs = 0;
  int pos = 0;
  bit exp_fs = 1'b0;
  bit prev_stall = 1'b0;
  logic signed [7:0] prev_data;
  logic signed [7:0] exp_q[$];
  vec_stream_if #(.WIDTH(8)) bus ();
  vec_stream_tx #(.WIDTH(8), .LEN(5), .LOGLEN(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      pos = 0;
      exp_fs = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_sent", int'(bus.frame_sent), int'(exp_fs));
      if (bus.frame_sent) begin
        prev_fs = last_fs;
        last_fs = cyc;
        fs_cnt++;
      end
      if (prev_stall) begin
        check("stall_valid", int'(bus.m_valid), 1);
        check("stall_data", int'($signed(bus.m_data_out)), int'(prev_data));
      end
      exp_fs = bus.m_valid && bus.m_ready && pos == 4;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", int'($signed(bus.m_data_out)), -999);
        else check("stream_data", int'($signed(bus.m_data_out)), int'(exp_q.pop_front()));
        pos = (pos + 1) % 5;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data_out;
    end
  end
  task automatic wr(input logic signed [7:0] d, input bit must_ready);
    int t = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    if (must_ready) check("wr_ready_accept", int'(bus.wr_ready), 1);
    while (!bus.wr_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.wr_ready) check("wr_timeout", 0, 1);
    else exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
  endtask
  task automatic wr_frame(input logic signed [7:0] f [5], input int max_gap);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      wr(f[i], 1'b0);
    end
  endtask
  task automatic drain(input bit rnd);
    int t = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && t < 400) begin
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 400) check("drain_timeout", 0, 1);
    bus.m_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!bus.m_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("wait_valid", int'(bus.m_valid), 1);
  endtask
  logic signed [7:0] fa [5] = '{8'sd6, -8'sd3, 8'sd11, 8'sd0, 8'sd127};
  logic signed [7:0] fb [5] = '{8'sd10, 8'sd11, 8'sd12, 8'sd13, 8'sd14};
  logic signed [7:0] fc [5] = '{8'sd20, 8'sd21, 8'sd22, 8'sd23, 8'sd24};
  logic signed [7:0] fd [5] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
  logic signed [7:0] fe [5] = '{-8'sd128, 8'sd1, -8'sd1, 8'sd64, -8'sd2};
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("wr_ready_in_reset", int'(bus.wr_ready), 0);
    @(posedge clk);
    #1;
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_m_data", int'(bus.m_data_out), 0);
    check("rst_banks_full", int'(bus.banks_full), 0);
    check("rst_frame_sent", int'(bus.frame_sent), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("wr_ready_after_reset", int'(bus.wr_ready), 1);
    // basic frame and latency
    for (int i = 0; i < 5; i++) wr(fa[i], 1'b1);
    check("lat_valid_edge_n", int'(bus.m_valid), 0);
    @(posedge clk);
    #1;
    check("lat_valid_edge_n1", int'(bus.m_valid), 1);
    check("lat_first_data", int'($signed(bus.m_data_out)), 6);
    drain(1'b0);
    check("basic_frames", fs_cnt, 1);
    check("basic_valid_low", int'(bus.m_valid), 0);
    // backpressure on element -3
    bus.m_ready = 1'b0;
    wr_frame(fa, 0);
    wait_valid();
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_hold_data", int'($signed(bus.m_data_out)), -3);
      check("bp_hold_valid", int'(bus.m_valid), 1);
      @(posedge clk);
      #1;
    end
    drain(1'b1);
    check("bp_frames", fs_cnt, 2);
    // ping-pong full
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(fb[i], 1'b1);
    for (int i = 0; i < 5; i++) wr(fc[i], 1'b1);
    @(negedge clk);
    check("pp_wr_ready_full", int'(bus.wr_ready), 0);
    check("pp_banks_full", int'(bus.banks_full), 3);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("pp_wr_ready_wait", int'(bus.wr_ready), 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("pp_wr_ready_back", int'(bus.wr_ready), 1);
    @(posedge clk);
    #1;
    wr_frame(fd, 0);
    drain(1'b0);
    check("pp_frames", fs_cnt, 5);
    // back-to-back frames
    bus.m_ready = 1'b0;
    wr_frame(fc, 0);
    wr_frame(fb, 0);
    @(negedge clk);
    check("b2b_banks_full", int'(bus.banks_full), 3);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("b2b_valid", int'(bus.m_valid), 1);
      @(posedge clk);
      #1;
    end
    drain(1'b0);
    check("b2b_frames", fs_cnt, 7);
    check("b2b_spacing", last_fs - prev_fs, 5);
    // reset mid-operation
    bus.m_ready = 1'b0;
    wr_frame(fb, 0);
    wr_frame(fc, 0);
    wait_valid();
    bus.m_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_valid", int'(bus.m_valid), 0);
    check("mid_rst_data", int'(bus.m_data_out), 0);
    check("mid_rst_banks", int'(bus.banks_full), 0);
    check("mid_rst_fs", int'(bus.frame_sent), 0);
    reset = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    wr_frame(fd, 0);
    drain(1'b0);
    check("rst_frames", fs_cnt, 8);
    // idle host gaps, including -128
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      wr(fe[i], 1'b0);
    end
    repeat (3) begin
      @(negedge clk);
      check("gap_no_tx", int'(bus.m_valid), 0);
      @(posedge clk);
      #1;
    end
    wr(fe[4], 1'b0);
    drain(1'b0);
    check("gap_frames", fs_cnt, 9);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
